// File: rtl/pic_ctrl_regs.sv
// rtl/pic_ctrl_regs.sv - 8259 PIC ICW/OCW command, configuration and read-back register stage
module pic_ctrl_regs #(
    parameter logic [7:0] RESET_IMR       = 8'h00,
    parameter logic       INIT_CLEARS_IMR = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_valid,
    input  logic [7:0] wr_data,
    input  logic       wr_type,
    input  logic [1:0] wr_nr,
    input  logic       rd_en,
    input  logic       rd_a0,
    input  logic [7:0] irr,
    input  logic [7:0] isr,
    input  logic       poll_hit,
    input  logic [2:0] poll_level,
    output logic [7:0] rd_data,
    output logic [7:0] imr,
    output logic [4:0] vector_base,
    output logic       ltim,
    output logic       sngl,
    output logic       ic4,
    output logic [7:0] icw3,
    output logic       upm,
    output logic       aeoi,
    output logic       ms,
    output logic       buf_mode,
    output logic       sfnm,
    output logic       init_done,
    output logic       init_pulse,
    output logic       cmd_valid,
    output logic [2:0] cmd_code,
    output logic [2:0] cmd_level,
    output logic       rotate_aeoi,
    output logic       smm,
    output logic       poll_ack,
    output logic       seq_err
);

    typedef enum logic [2:0] {
        UNINIT    = 3'd0,
        WAIT_ICW2 = 3'd1,
        WAIT_ICW3 = 3'd2,
        WAIT_ICW4 = 3'd3,
        READY     = 3'd4
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       icw1_ok, icw2_ok, icw3_ok, icw4_ok;
    logic       ocw1_ok, ocw2_ok, ocw3_ok, wr_ok;
    logic       ocw2_live;
    logic       read_isr;
    logic       poll_pending;
    logic [2:0] ocw2_code;

    assign ocw2_code = wr_data[7:5];

    // Write acceptance: ICW1 always, other ICWs only in their slot, OCWs only once ready
    always_comb begin
        icw1_ok   = wr_valid && wr_type && (wr_nr == 2'd0);
        icw2_ok   = wr_valid && wr_type && (wr_nr == 2'd1) && (state == WAIT_ICW2);
        icw3_ok   = wr_valid && wr_type && (wr_nr == 2'd2) && (state == WAIT_ICW3);
        icw4_ok   = wr_valid && wr_type && (wr_nr == 2'd3) && (state == WAIT_ICW4);
        ocw1_ok   = wr_valid && !wr_type && (wr_nr == 2'd0) && (state == READY);
        ocw2_ok   = wr_valid && !wr_type && (wr_nr == 2'd1) && (state == READY);
        ocw3_ok   = wr_valid && !wr_type && (wr_nr == 2'd2) && (state == READY);
        wr_ok     = icw1_ok || icw2_ok || icw3_ok || icw4_ok || ocw1_ok || ocw2_ok || ocw3_ok;
        ocw2_live = ocw2_ok && (ocw2_code != 3'b010);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= UNINIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (icw1_ok) begin
            state_next = WAIT_ICW2;
        end else if (icw2_ok) begin
            if (!sngl) begin
                state_next = WAIT_ICW3;
            end else if (ic4) begin
                state_next = WAIT_ICW4;
            end else begin
                state_next = READY;
            end
        end else if (icw3_ok) begin
            state_next = ic4 ? WAIT_ICW4 : READY;
        end else if (icw4_ok) begin
            state_next = READY;
        end
    end

    always_comb begin
        init_done = (state == READY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            imr          <= RESET_IMR;
            vector_base  <= 5'd0;
            ltim         <= 1'b0;
            sngl         <= 1'b0;
            ic4          <= 1'b0;
            icw3         <= 8'h00;
            {sfnm, buf_mode, ms, aeoi, upm} <= 5'd0;
            init_pulse   <= 1'b0;
            seq_err      <= 1'b0;
            cmd_valid    <= 1'b0;
            cmd_code     <= 3'd0;
            cmd_level    <= 3'd0;
            rotate_aeoi  <= 1'b0;
            smm          <= 1'b0;
            read_isr     <= 1'b0;
            poll_pending <= 1'b0;
            poll_ack     <= 1'b0;
            rd_data      <= 8'h00;
        end else begin
            init_pulse <= icw1_ok;
            seq_err    <= wr_valid && !wr_ok;
            cmd_valid  <= ocw2_live;
            poll_ack   <= 1'b0;

            if (icw1_ok) begin
                ltim        <= wr_data[3];
                sngl        <= wr_data[1];
                ic4         <= wr_data[0];
                icw3        <= 8'h00;
                {sfnm, buf_mode, ms, aeoi, upm} <= 5'd0;
                smm         <= 1'b0;
                rotate_aeoi <= 1'b0;
                read_isr    <= 1'b0;
                if (INIT_CLEARS_IMR) begin
                    imr <= 8'h00;
                end
            end
            if (icw2_ok) begin
                vector_base <= wr_data[7:3];
            end
            if (icw3_ok) begin
                icw3 <= wr_data;
            end
            if (icw4_ok) begin
                {sfnm, buf_mode, ms, aeoi, upm} <= wr_data[4:0];
            end
            if (ocw1_ok) begin
                imr <= wr_data;
            end
            if (ocw2_live) begin
                cmd_code  <= ocw2_code;
                cmd_level <= wr_data[2:0];
            end
            if (ocw2_ok && ocw2_code == 3'b100) begin
                rotate_aeoi <= 1'b1;
            end else if (ocw2_ok && ocw2_code == 3'b000) begin
                rotate_aeoi <= 1'b0;
            end
            if (ocw3_ok && wr_data[6]) begin
                smm <= wr_data[5];
            end
            if (ocw3_ok && wr_data[1]) begin
                read_isr <= wr_data[0];
            end

            // Reads see pre-write state; a poll armed by a concurrent write survives this read
            if (rd_en) begin
                if (rd_a0) begin
                    rd_data <= imr;
                end else if (poll_pending) begin
                    rd_data  <= {poll_hit, 4'b0000, poll_level};
                    poll_ack <= 1'b1;
                end else begin
                    rd_data <= read_isr ? isr : irr;
                end
            end

            if (icw1_ok) begin
                poll_pending <= 1'b0;
            end else if (ocw3_ok && wr_data[2]) begin
                poll_pending <= 1'b1;
            end else if (rd_en && !rd_a0 && poll_pending) begin
                poll_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pic_ctrl_regs.sv
// tb/tb_pic_ctrl_regs.sv - directed vector table plus randomized reference-model check of pic_ctrl_regs
module tb_pic_ctrl_regs;

    localparam logic [7:0] P_RESET_IMR = 8'h00;
    localparam logic       P_INIT_CLR  = 1'b1;

    logic       clk;
    logic       reset;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_type;
    logic [1:0] wr_nr;
    logic       rd_en;
    logic       rd_a0;
    logic [7:0] irr;
    logic [7:0] isr;
    logic       poll_hit;
    logic [2:0] poll_level;
    logic [7:0] rd_data;
    logic [7:0] imr;
    logic [4:0] vector_base;
    logic       ltim, sngl, ic4;
    logic [7:0] icw3;
    logic       upm, aeoi, ms, buf_mode, sfnm;
    logic       init_done, init_pulse, cmd_valid;
    logic [2:0] cmd_code, cmd_level;
    logic       rotate_aeoi, smm, poll_ack, seq_err;

    pic_ctrl_regs #(
        .RESET_IMR      (P_RESET_IMR),
        .INIT_CLEARS_IMR(P_INIT_CLR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_type    (wr_type),
        .wr_nr      (wr_nr),
        .rd_en      (rd_en),
        .rd_a0      (rd_a0),
        .irr        (irr),
        .isr        (isr),
        .poll_hit   (poll_hit),
        .poll_level (poll_level),
        .rd_data    (rd_data),
        .imr        (imr),
        .vector_base(vector_base),
        .ltim       (ltim),
        .sngl       (sngl),
        .ic4        (ic4),
        .icw3       (icw3),
        .upm        (upm),
        .aeoi       (aeoi),
        .ms         (ms),
        .buf_mode   (buf_mode),
        .sfnm       (sfnm),
        .init_done  (init_done),
        .init_pulse (init_pulse),
        .cmd_valid  (cmd_valid),
        .cmd_code   (cmd_code),
        .cmd_level  (cmd_level),
        .rotate_aeoi(rotate_aeoi),
        .smm        (smm),
        .poll_ack   (poll_ack),
        .seq_err    (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {
        S_NONE, S_RD, S_IMR, S_VB, S_LTIM, S_SNGL, S_IC4, S_ICW3, S_UPM, S_AEOI, S_MS,
        S_BUF, S_SFNM, S_INIT_DONE, S_INIT_PULSE, S_CMD_VALID, S_CMD_CODE, S_CMD_LEVEL,
        S_ROT, S_SMM, S_POLL_ACK, S_SEQ_ERR, S_LAST
    } sig_t;

    typedef struct {
        logic       rst;
        logic       wv;
        logic       wt;
        logic [1:0] wn;
        logic [7:0] wd;
        logic       re;
        logic       ra0;
        sig_t       sa;
        logic [7:0] ea;
        sig_t       sb;
        logic [7:0] eb;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: the init sequence is a queue of still-expected ICW numbers
    logic [7:0] m_imr, m_icw3, m_rd;
    logic [4:0] m_vb, m_icw4;
    logic       m_ltim, m_sngl, m_ic4, m_inited, m_smm, m_rot, m_rsel, m_poll;
    logic       m_init_pulse, m_cmd_valid, m_poll_ack, m_seq_err;
    logic [2:0] m_code, m_level;
    int         exp_q[$];

    logic       r_rst, r_wv, r_wt, r_re, r_ra0;
    logic [1:0] r_wn;
    logic [7:0] r_wd;

    function automatic logic m_ready();
        return m_inited && (exp_q.size() == 0);
    endfunction

    task automatic model_reset();
        m_imr = P_RESET_IMR; m_icw3 = 8'h00; m_rd = 8'h00; m_vb = 5'd0; m_icw4 = 5'd0;
        m_ltim = 0; m_sngl = 0; m_ic4 = 0; m_inited = 0; m_smm = 0; m_rot = 0; m_rsel = 0;
        m_poll = 0; m_init_pulse = 0; m_cmd_valid = 0; m_poll_ack = 0; m_seq_err = 0;
        m_code = 3'd0; m_level = 3'd0;
        exp_q.delete();
    endtask

    task automatic model_step();
        logic [2:0] code;
        m_init_pulse = 0; m_cmd_valid = 0; m_poll_ack = 0; m_seq_err = 0;
        if (reset) begin
            model_reset();
        end else begin
            if (rd_en) begin
                if (rd_a0) m_rd = m_imr;
                else if (m_poll) begin
                    m_rd = {poll_hit, 4'b0000, poll_level};
                    m_poll = 0;
                    m_poll_ack = 1;
                end else m_rd = m_rsel ? isr : irr;
            end
            if (wr_valid) begin
                if (wr_type && wr_nr == 2'd0) begin
                    m_inited = 1; m_init_pulse = 1;
                    m_ltim = wr_data[3]; m_sngl = wr_data[1]; m_ic4 = wr_data[0];
                    exp_q = {1};
                    if (!wr_data[1]) exp_q.push_back(2);
                    if (wr_data[0]) exp_q.push_back(3);
                    m_icw3 = 8'h00; m_icw4 = 5'd0; m_smm = 0; m_rot = 0; m_rsel = 0; m_poll = 0;
                    if (P_INIT_CLR) m_imr = 8'h00;
                end else if (wr_type) begin
                    if (exp_q.size() != 0 && exp_q[0] == int'(wr_nr)) begin
                        case (wr_nr)
                            2'd1:    m_vb = wr_data[7:3];
                            2'd2:    m_icw3 = wr_data;
                            default: m_icw4 = wr_data[4:0];
                        endcase
                        void'(exp_q.pop_front());
                    end else m_seq_err = 1;
                end else if (!m_ready() || wr_nr == 2'd3) begin
                    m_seq_err = 1;
                end else begin
                    case (wr_nr)
                        2'd0: m_imr = wr_data;
                        2'd1: begin
                            code = wr_data[7:5];
                            if (code != 3'b010) begin
                                m_cmd_valid = 1; m_code = code; m_level = wr_data[2:0];
                            end
                            if (code == 3'b100) m_rot = 1;
                            if (code == 3'b000) m_rot = 0;
                        end
                        default: begin
                            if (wr_data[6]) m_smm = wr_data[5];
                            if (wr_data[1]) m_rsel = wr_data[0];
                            if (wr_data[2]) m_poll = 1;
                        end
                    endcase
                end
            end
        end
    endtask

    function automatic logic [7:0] dut_sig(sig_t s);
        case (s)
            S_RD:         return rd_data;
            S_IMR:        return imr;
            S_VB:         return {3'b000, vector_base};
            S_LTIM:       return {7'd0, ltim};
            S_SNGL:       return {7'd0, sngl};
            S_IC4:        return {7'd0, ic4};
            S_ICW3:       return icw3;
            S_UPM:        return {7'd0, upm};
            S_AEOI:       return {7'd0, aeoi};
            S_MS:         return {7'd0, ms};
            S_BUF:        return {7'd0, buf_mode};
            S_SFNM:       return {7'd0, sfnm};
            S_INIT_DONE:  return {7'd0, init_done};
            S_INIT_PULSE: return {7'd0, init_pulse};
            S_CMD_VALID:  return {7'd0, cmd_valid};
            S_CMD_CODE:   return {5'd0, cmd_code};
            S_CMD_LEVEL:  return {5'd0, cmd_level};
            S_ROT:        return {7'd0, rotate_aeoi};
            S_SMM:        return {7'd0, smm};
            S_POLL_ACK:   return {7'd0, poll_ack};
            S_SEQ_ERR:    return {7'd0, seq_err};
            default:      return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] model_sig(sig_t s);
        case (s)
            S_RD:         return m_rd;
            S_IMR:        return m_imr;
            S_VB:         return {3'b000, m_vb};
            S_LTIM:       return {7'd0, m_ltim};
            S_SNGL:       return {7'd0, m_sngl};
            S_IC4:        return {7'd0, m_ic4};
            S_ICW3:       return m_icw3;
            S_UPM:        return {7'd0, m_icw4[0]};
            S_AEOI:       return {7'd0, m_icw4[1]};
            S_MS:         return {7'd0, m_icw4[2]};
            S_BUF:        return {7'd0, m_icw4[3]};
            S_SFNM:       return {7'd0, m_icw4[4]};
            S_INIT_DONE:  return {7'd0, m_ready()};
            S_INIT_PULSE: return {7'd0, m_init_pulse};
            S_CMD_VALID:  return {7'd0, m_cmd_valid};
            S_CMD_CODE:   return {5'd0, m_code};
            S_CMD_LEVEL:  return {5'd0, m_level};
            S_ROT:        return {7'd0, m_rot};
            S_SMM:        return {7'd0, m_smm};
            S_POLL_ACK:   return {7'd0, m_poll_ack};
            S_SEQ_ERR:    return {7'd0, m_seq_err};
            default:      return 8'h00;
        endcase
    endfunction

    task automatic chk(input string tag, input sig_t s, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s at %0t: got %h expected %h", tag, s.name(), $time, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic wv, input logic wt, input logic [1:0] wn,
                        input logic [7:0] wd, input logic re, input logic ra0);
        reset = rst; wr_valid = wv; wr_type = wt; wr_nr = wn; wr_data = wd; rd_en = re; rd_a0 = ra0;
        @(posedge clk);
        model_step();
        #1;
        for (int i = 1; i < int'(S_LAST); i++) begin
            chk("model", sig_t'(i), dut_sig(sig_t'(i)), model_sig(sig_t'(i)));
        end
        reset = 0; wr_valid = 0; rd_en = 0; rd_a0 = 0;
    endtask

    task automatic add(input logic rst, input logic wv, input logic wt, input logic [1:0] wn,
                       input logic [7:0] wd, input logic re, input logic ra0,
                       input sig_t sa, input logic [7:0] ea, input sig_t sb, input logic [7:0] eb);
        vecs.push_back('{rst, wv, wt, wn, wd, re, ra0, sa, ea, sb, eb});
    endtask

    initial begin
        reset = 0; wr_valid = 0; wr_data = 0; wr_type = 0; wr_nr = 0; rd_en = 0; rd_a0 = 0;
        irr = 8'h05; isr = 8'h10; poll_hit = 1; poll_level = 3'd6;
        model_reset();

        //   rst wv wt wn    wd     re ra0  check a           check b
        add(1, 0, 0, 2'd0, 8'h00, 0, 0, S_INIT_DONE, 8'h00, S_IMR, 8'h00);
        add(0, 1, 1, 2'd0, 8'h13, 0, 0, S_INIT_PULSE, 8'h01, S_SNGL, 8'h01);
        add(0, 1, 1, 2'd1, 8'h48, 0, 0, S_VB, 8'h09, S_INIT_DONE, 8'h00);
        add(0, 1, 1, 2'd3, 8'h03, 0, 0, S_INIT_DONE, 8'h01, S_AEOI, 8'h01);
        add(0, 0, 0, 2'd0, 8'h00, 0, 0, S_UPM, 8'h01, S_SEQ_ERR, 8'h00);
        add(0, 1, 1, 2'd0, 8'h11, 0, 0, S_IC4, 8'h01, S_SNGL, 8'h00);
        add(0, 1, 1, 2'd1, 8'h20, 0, 0, S_VB, 8'h04, S_INIT_DONE, 8'h00);
        add(0, 1, 1, 2'd2, 8'h04, 0, 0, S_ICW3, 8'h04, S_INIT_DONE, 8'h00);
        add(0, 1, 1, 2'd3, 8'h01, 0, 0, S_INIT_DONE, 8'h01, S_UPM, 8'h01);
        add(0, 1, 0, 2'd0, 8'hFB, 0, 0, S_IMR, 8'hFB, S_SEQ_ERR, 8'h00);
        add(0, 0, 0, 2'd0, 8'h00, 1, 1, S_RD, 8'hFB, S_NONE, 8'h00);
        add(0, 1, 0, 2'd1, 8'h63, 0, 0, S_CMD_VALID, 8'h01, S_CMD_CODE, 8'h03);
        add(0, 0, 0, 2'd0, 8'h00, 0, 0, S_CMD_VALID, 8'h00, S_CMD_LEVEL, 8'h03);
        add(0, 1, 0, 2'd1, 8'h80, 0, 0, S_ROT, 8'h01, S_CMD_VALID, 8'h01);
        add(0, 1, 0, 2'd1, 8'h40, 0, 0, S_CMD_VALID, 8'h00, S_ROT, 8'h01);
        add(0, 1, 0, 2'd2, 8'h0B, 0, 0, S_SMM, 8'h00, S_SEQ_ERR, 8'h00);
        add(0, 0, 0, 2'd0, 8'h00, 1, 0, S_RD, 8'h10, S_NONE, 8'h00);
        add(0, 1, 0, 2'd2, 8'h0A, 0, 0, S_NONE, 8'h00, S_NONE, 8'h00);
        add(0, 0, 0, 2'd0, 8'h00, 1, 0, S_RD, 8'h05, S_NONE, 8'h00);
        add(0, 1, 0, 2'd2, 8'h68, 0, 0, S_SMM, 8'h01, S_NONE, 8'h00);
        add(0, 1, 0, 2'd2, 8'h0C, 0, 0, S_POLL_ACK, 8'h00, S_NONE, 8'h00);
        add(0, 0, 0, 2'd0, 8'h00, 1, 0, S_RD, 8'h86, S_POLL_ACK, 8'h01);
        add(0, 0, 0, 2'd0, 8'h00, 1, 0, S_RD, 8'h05, S_POLL_ACK, 8'h00);
        add(0, 1, 0, 2'd0, 8'hAA, 1, 1, S_RD, 8'hFB, S_IMR, 8'hAA);
        add(0, 0, 0, 2'd0, 8'h00, 1, 1, S_RD, 8'hAA, S_NONE, 8'h00);
        add(0, 1, 0, 2'd2, 8'h0C, 1, 0, S_RD, 8'h05, S_POLL_ACK, 8'h00);
        add(0, 0, 0, 2'd0, 8'h00, 1, 0, S_RD, 8'h86, S_POLL_ACK, 8'h01);
        add(0, 1, 1, 2'd1, 8'h00, 0, 0, S_SEQ_ERR, 8'h01, S_VB, 8'h04);
        add(1, 0, 0, 2'd0, 8'h00, 0, 0, S_INIT_DONE, 8'h00, S_IMR, 8'h00);
        add(0, 1, 0, 2'd0, 8'h55, 0, 0, S_SEQ_ERR, 8'h01, S_IMR, 8'h00);
        add(0, 1, 1, 2'd0, 8'h11, 0, 0, S_INIT_PULSE, 8'h01, S_SEQ_ERR, 8'h00);
        add(0, 1, 1, 2'd1, 8'h20, 0, 0, S_NONE, 8'h00, S_NONE, 8'h00);
        add(0, 1, 1, 2'd0, 8'h10, 0, 0, S_INIT_PULSE, 8'h01, S_IC4, 8'h00);
        add(0, 1, 1, 2'd2, 8'h04, 0, 0, S_SEQ_ERR, 8'h01, S_ICW3, 8'h00);
        add(0, 1, 1, 2'd1, 8'h30, 0, 0, S_VB, 8'h06, S_SEQ_ERR, 8'h00);
        add(0, 1, 1, 2'd2, 8'h02, 0, 0, S_ICW3, 8'h02, S_INIT_DONE, 8'h01);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].wv, vecs[i].wt, vecs[i].wn, vecs[i].wd, vecs[i].re, vecs[i].ra0);
            if (vecs[i].sa != S_NONE) chk("vector", vecs[i].sa, dut_sig(vecs[i].sa), vecs[i].ea);
            if (vecs[i].sb != S_NONE) chk("vector", vecs[i].sb, dut_sig(vecs[i].sb), vecs[i].eb);
        end

        // Reset mid-sequence: every output returns to its reset value
        step(0, 1, 1, 2'd0, 8'hFF, 0, 0);
        step(0, 1, 1, 2'd1, 8'hF8, 1, 0);
        step(1, 1, 0, 2'd1, 8'h63, 0, 0);
        for (int i = 1; i < int'(S_LAST); i++) begin
            chk("midreset", sig_t'(i), dut_sig(sig_t'(i)), (sig_t'(i) == S_IMR) ? P_RESET_IMR : 8'h00);
        end

        for (int n = 0; n < 4000; n++) begin
            irr = 8'($urandom_range(0, 255));
            isr = 8'($urandom_range(0, 255));
            poll_hit = 1'($urandom_range(0, 1));
            poll_level = 3'($urandom_range(0, 7));
            r_rst = ($urandom_range(0, 299) == 0);
            r_wv = 1'($urandom_range(0, 1));
            r_wd = 8'($urandom_range(0, 255));
            r_re = 1'($urandom_range(0, 1));
            r_ra0 = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 29) == 0) begin
                r_wt = 1; r_wn = 2'd0;
            end else if (exp_q.size() != 0 && $urandom_range(0, 3) != 0) begin
                r_wt = 1; r_wn = 2'(exp_q[0]);
            end else if (!m_inited && $urandom_range(0, 1) == 0) begin
                r_wt = 1; r_wn = 2'd0;
            end else begin
                r_wt = ($urandom_range(0, 7) == 0);
                r_wn = 2'($urandom_range(0, 3));
                if (r_wt && r_wn == 2'd0) r_wn = 2'd1;
            end
            step(r_rst, r_wv, r_wt, r_wn, r_wd, r_re, r_ra0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pic_ctrl_regs.md
Name: pic_ctrl_regs

Overview:
- Command/configuration register stage of the 8259 PIC; directly downstream of the CPU read/write interface block.
- Consumes tagged write words (data, ICW/OCW type, word number), sequences ICW1..ICW4 initialisation and holds the resulting configuration.
- Decodes OCW1/2/3 into the mask register, EOI/rotate command pulses and read-select state.
- Drives the registered read-back byte (IRR/ISR/IMR/poll word) returned to the CPU interface.

Parameters:
- RESET_IMR, 8'h00, IMR value after reset.
- INIT_CLEARS_IMR, 1, when 1 an accepted ICW1 loads IMR with 8'h00.

Ports:
- clk  in  1  single system clock, all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- wr_valid  in  1  one-cycle strobe, a tagged write word is present.
- wr_data  in  8  write word.
- wr_type  in  1  1=ICW, 0=OCW.
- wr_nr  in  2  ICW: 0..3 = ICW1..ICW4; OCW: 0=OCW1, 1=OCW2, 2=OCW3.
- rd_en  in  1  one-cycle read strobe.
- rd_a0  in  1  A0 of the read cycle.
- irr  in  8  interrupt request register from the request latch.
- isr  in  8  in-service register from the priority resolver.
- poll_hit  in  1  resolver has a pending request.
- poll_level  in  3  highest-priority pending level.
- rd_data  out  8  registered read-back byte.
- imr  out  8  interrupt mask.
- vector_base  out  5  ICW2[7:3].
- ltim, sngl, ic4  out  1 each  ICW1 bits 3, 1, 0.
- icw3  out  8  cascade word.
- upm, aeoi, ms, buf_mode, sfnm  out  1 each  ICW4 bits 0..4.
- init_done  out  1  initialisation complete, OCWs accepted.
- init_pulse  out  1  one cycle on accepted ICW1 (clears ISR and priority downstream).
- cmd_valid  out  1  one-cycle OCW2 command strobe.
- cmd_code  out  3  OCW2[7:5] (R, SL, EOI).
- cmd_level  out  3  OCW2[2:0].
- rotate_aeoi  out  1  rotate-in-AEOI mode flag.
- smm  out  1  special mask mode.
- poll_ack  out  1  one cycle when the poll word is read.
- seq_err  out  1  one cycle when a write is rejected.

Behaviour:
- Reset values: all outputs 0, except imr=RESET_IMR. The state machine goes to UNINIT. The read-select flag picks IRR. poll_pending=0.
- States: UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY. init_done=1 only in READY.
- ICW1 (type=1, nr=0) is accepted in any state:
  - Latches ltim, sngl, ic4 and pulses init_pulse.
  - Clears icw3, ICW4 fields, smm, rotate_aeoi and poll_pending. The read select goes back to IRR. imr is cleared if INIT_CLEARS_IMR.
  - Next state is WAIT_ICW2.
- WAIT_ICW2 + ICW2: latches vector_base. Next state is WAIT_ICW3 if sngl=0, else WAIT_ICW4 if ic4=1, else READY.
- WAIT_ICW3 + ICW3: latches icw3. Next state is WAIT_ICW4 if ic4=1, else READY.
- WAIT_ICW4 + ICW4: latches upm, aeoi, ms, buf_mode, sfnm. Next state is READY.
- Rejected writes are ignored, with no state or register change, and pulse seq_err the next cycle:
  - an ICW with a word number not expected in the current state;
  - any OCW outside READY;
  - any ICW2..ICW4 in READY or UNINIT.
- OCW1 in READY: imr <= wr_data.
- OCW2 in READY: cmd_valid, cmd_code, cmd_level are registered with 1-cycle latency and are valid for exactly one cycle. Additionally:
  - code 3'b100 sets rotate_aeoi;
  - code 3'b000 clears rotate_aeoi;
  - code 3'b010 (no-op) raises no cmd_valid.
- OCW3 in READY:
  - if bit6 (ESMM)=1, smm <= bit5;
  - if bit1 (RR)=1, read select <= bit0 (1=ISR, 0=IRR);
  - if bit2 (P)=1, poll_pending <= 1. Poll takes precedence over RR in the same word for reads.
- Read, 1-cycle latency: rd_data is updated on the cycle after rd_en and holds until the next read.
  - rd_a0=1: imr.
  - rd_a0=0 with poll_pending: {poll_hit, 4'b0, poll_level}. Clears poll_pending and pulses poll_ack in the same cycle rd_data updates.
  - Otherwise ISR or IRR per the read select.
- wr_valid and rd_en in the same cycle: both are serviced. The read returns pre-write register values, except that a poll requested by the same write is not served by this read.
- ICW1 arriving mid-sequence restarts at WAIT_ICW2. reset mid-sequence forces UNINIT in the next cycle.

Test Plan:
- Reset, then ICW1=8'h13, ICW2=8'h48, ICW4=8'h03 -> sngl=1, ic4=1, vector_base=5'h09, aeoi=1, upm=1, init_done=1 after the ICW4 cycle, no seq_err.
- ICW1=8'h11, ICW2=8'h20, ICW3=8'h04, ICW4=8'h01, then OCW1=8'hFB, then read rd_a0=1 -> icw3=8'h04, imr=8'hFB, rd_data=8'hFB one cycle after rd_en.
- In READY, OCW2=8'h63 -> one-cycle cmd_valid, cmd_code=3'b011, cmd_level=3; OCW2=8'h80 -> rotate_aeoi=1; OCW2=8'h40 -> no cmd_valid.
- OCW3=8'h0B, irr=8'h05, isr=8'h10, read rd_a0=0 -> rd_data=8'h10; OCW3=8'h0A -> rd_data=8'h05; OCW3=8'h68 -> smm=1.
- OCW3=8'h0C, poll_hit=1, poll_level=6, read -> rd_data=8'h86 with poll_ack pulse; next read returns IRR.
- OCW1 before any ICW1 -> seq_err pulse, imr unchanged; ICW1 issued while in WAIT_ICW3 -> init_pulse, state WAIT_ICW2; reset asserted mid-sequence -> all outputs at reset values.
